addsub_mp_ctrl: RTL

//   Multi-precision add/subtract sequencer. Accepts WORDS*N-bit operands with a

---
 rtl/addsub_mp_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/addsub_mp_ctrl.sv
// Multi-precision add/subtract sequencer: one N-bit slice per clock, LS slice
// first, with a registered inter-slice carry and N/Z/V/C flags at completion.
module addsub_mp_ctrl #(
   parameter int unsigned N     = 8,
   parameter int unsigned WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sub,
   input  logic [N*WORDS-1:0]   x,
   input  logic [N*WORDS-1:0]   y,
   output logic                 busy,
   output logic                 done,
   output logic [N*WORDS-1:0]   result,
   output logic                 ccn,
   output logic                 ccz,
   output logic                 ccv,
   output logic                 ccc
);

   localparam int unsigned W  = N * WORDS;
   localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic            c;
   logic            sub_r;
   logic [W-1:0]    x_r;
   logic [W-1:0]    y_r;
   logic [W-1:0]    work;

   int unsigned     base;
   logic [N-1:0]    xs;
   logic [N-1:0]    ys;
   logic [N:0]      sum;
   logic            cin_msb;
   logic            last;
   logic [W-1:0]    full;

   always_comb begin
      base    = N * 32'(k);
      xs      = x_r[base +: N];
      ys      = y_r[base +: N] ^ {N{sub_r}};
      sum     = {1'b0, xs} + {1'b0, ys} + {{N{1'b0}}, c};
      // carry into the slice MSB recovered from the MSB sum bit and its operands
      cin_msb = sum[N-1] ^ xs[N-1] ^ ys[N-1];
      last    = (k == KW'(WORDS - 1));
      full    = work;
      full[base +: N] = sum[N-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         k      <= '0;
         c      <= 1'b0;
         sub_r  <= 1'b0;
         x_r    <= '0;
         y_r    <= '0;
         work   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         ccn    <= 1'b0;
         ccz    <= 1'b0;
         ccv    <= 1'b0;
         ccc    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  x_r   <= x;
                  y_r   <= y;
                  sub_r <= sub;
                  c     <= sub;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               work <= full;
               c    <= sum[N];
               k    <= k + KW'(1);
               if (last) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= full;
                  ccn    <= full[W-1];
                  ccz    <= (full == '0);
                  ccc    <= sum[N];
                  ccv    <= sum[N] ^ cin_msb;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
